// File: rtl/rrc_polyphase_tx_filter.sv
// Multi-channel polyphase pulse-shaping interpolator: one symbol per channel
// every OS accepted samples, one filtered output sample per accepted strobe.
module rrc_polyphase_tx_filter #(
  parameter int unsigned OS        = 4,
  parameter int unsigned TAPS      = 6,
  parameter int unsigned S_COEF    = 8,
  parameter int unsigned S_IN      = 2,
  parameter int unsigned N_CH      = 2,
  parameter int unsigned S_OUT     = 10,
  parameter int unsigned OUT_SHIFT = 0,
  parameter int unsigned AW        = $clog2(TAPS * OS)
) (
  input  logic                    clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_clear,
  input  logic                    i_valid,
  input  logic [N_CH*S_IN-1:0]    i_symbols,
  input  logic                    i_coef_we,
  input  logic [AW-1:0]           i_coef_addr,
  input  logic [S_COEF-1:0]       i_coef_data,
  output logic [N_CH*S_OUT-1:0]   o_data,
  output logic                    o_valid,
  output logic [N_CH-1:0]         o_sat
);

  localparam int unsigned NCOEF  = TAPS * OS;
  localparam int unsigned PW     = (OS > 1) ? $clog2(OS) : 1;
  localparam int unsigned W_FULL = S_COEF + S_IN + $clog2(TAPS) + 1;
  // One extra bit so the rounding offset can never wrap the sum
  localparam int unsigned W_ACC  = W_FULL + 1;
  localparam int unsigned RND_I  = (2 ** OUT_SHIFT) / 2;
  localparam logic signed [W_ACC-1:0] SAT_MAX = W_ACC'((2 ** (S_OUT - 1)) - 1);
  localparam logic signed [W_ACC-1:0] SAT_MIN = ~SAT_MAX;

  logic [PW-1:0]             phase_q, phase_d;
  logic signed [S_IN-1:0]    hist_q [N_CH][TAPS];
  logic signed [S_IN-1:0]    hist_d [N_CH][TAPS];
  logic signed [S_COEF-1:0]  coef_q [NCOEF];
  logic signed [S_COEF-1:0]  coef_d [NCOEF];
  logic                      acc_s1_q, acc_s1_d;
  logic [PW-1:0]             ph_s1_q, ph_s1_d;
  logic [N_CH*S_OUT-1:0]     data_q, data_d;
  logic                      valid_q, valid_d;
  logic [N_CH-1:0]           sat_q, sat_d;
  logic                      accept_c;
  logic signed [W_FULL-1:0]  sum_c;
  logic signed [W_ACC-1:0]   rnd_c;
  logic [AW-1:0]             idx_c;

  assign accept_c = i_enable & i_valid & ~i_clear;

  // Front end: phase counter, symbol history, coefficient RAM, stage-1 phase capture
  always_comb begin
    phase_d  = phase_q;
    hist_d   = hist_q;
    coef_d   = coef_q;
    acc_s1_d = accept_c;
    ph_s1_d  = phase_q;

    if (i_coef_we && (32'(i_coef_addr) < NCOEF)) begin
      coef_d[i_coef_addr] = i_coef_data;
    end

    if (i_clear) begin
      phase_d = '0;
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          hist_d[c][k] = '0;
        end
      end
    end else if (!i_enable) begin
      phase_d = '0;
    end else if (i_valid) begin
      if (phase_q == '0) begin
        for (int c = 0; c < N_CH; c++) begin
          for (int k = 1; k < TAPS; k++) begin
            hist_d[c][k] = hist_q[c][k-1];
          end
          hist_d[c][0] = $signed(i_symbols[c*S_IN +: S_IN]);
        end
      end
      phase_d = (phase_q == PW'(OS - 1)) ? '0 : phase_q + PW'(1);
    end
  end

  // Front-end state registers
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      phase_q  <= '0;
      acc_s1_q <= 1'b0;
      ph_s1_q  <= '0;
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          hist_q[c][k] <= '0;
        end
      end
      for (int n = 0; n < NCOEF; n++) begin
        coef_q[n] <= '0;
      end
    end else begin
      phase_q  <= phase_d;
      acc_s1_q <= acc_s1_d;
      ph_s1_q  <= ph_s1_d;
      hist_q   <= hist_d;
      coef_q   <= coef_d;
    end
  end

  // Output stage: polyphase dot product, round half up, saturate; hold between strobes
  always_comb begin
    data_d  = data_q;
    sat_d   = sat_q;
    valid_d = acc_s1_q;
    sum_c   = '0;
    rnd_c   = '0;
    idx_c   = '0;
    if (acc_s1_q) begin
      for (int c = 0; c < N_CH; c++) begin
        sum_c = '0;
        for (int k = 0; k < TAPS; k++) begin
          idx_c = AW'(k * OS) + AW'(ph_s1_q);
          sum_c = sum_c + W_FULL'(coef_q[idx_c]) * W_FULL'(hist_q[c][k]);
        end
        rnd_c = ($signed(W_ACC'(sum_c)) + $signed(W_ACC'(RND_I))) >>> OUT_SHIFT;
        if (rnd_c > SAT_MAX) begin
          data_d[c*S_OUT +: S_OUT] = S_OUT'(SAT_MAX);
          sat_d[c]                 = 1'b1;
        end else if (rnd_c < SAT_MIN) begin
          data_d[c*S_OUT +: S_OUT] = S_OUT'(SAT_MIN);
          sat_d[c]                 = 1'b1;
        end else begin
          data_d[c*S_OUT +: S_OUT] = S_OUT'(rnd_c);
          sat_d[c]                 = 1'b0;
        end
      end
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_sat   = sat_q;

endmodule

// File: doc/rrc_polyphase_tx_filter.md
Name: rrc_polyphase_tx_filter

Overview:
Multi-channel polyphase pulse-shaping interpolator for the transmitter chain. It sits between the symbol mapper and the DAC/channel model. It accepts one S_IN-bit signed symbol per channel every OS samples and emits OS filtered samples per symbol. Coefficients are runtime-loadable, output rounding and saturation are configurable, and every output carries a valid strobe.

Parameters:
OS, 4, oversampling factor (samples per symbol), >=2
TAPS, 6, symbol taps per polyphase branch (impulse length = TAPS*OS)
S_COEF, 8, signed coefficient width
S_IN, 2, signed symbol width per channel
N_CH, 2, number of channels (e.g. I/Q) sharing one coefficient set
S_OUT, 10, signed output width per channel
OUT_SHIFT, 0, arithmetic right shift applied to the full-precision sum before saturation
AW, $clog2(TAPS*OS), coefficient address width (derived)

Ports:
clock  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_enable  in  1  block enable; low = hold/idle
i_clear  in  1  synchronous flush of symbol history and phase
i_valid  in  1  sample-rate strobe; one output sample per accepted strobe
i_symbols  in  N_CH*S_IN  packed symbols, channel c at [c*S_IN +: S_IN]
i_coef_we  in  1  coefficient write enable
i_coef_addr  in  AW  coefficient index n (0..TAPS*OS-1)
i_coef_data  in  S_COEF  signed coefficient value
o_data  out  N_CH*S_OUT  packed filtered samples, same channel packing as input
o_valid  out  1  one-cycle strobe qualifying o_data
o_sat  out  N_CH  per-channel saturation flag for the current o_data

Behaviour:
- Reset (i_reset=0, asynchronous): phase=0, all symbol history=0, all coefficients=0, o_data=0, o_valid=0, o_sat=0.
- Accept: a sample is accepted at a rising edge when i_enable=1, i_valid=1 and i_clear=0.
- Phase counter p cycles 0..OS-1. It increments on each accept and wraps from OS-1 to 0.
- Symbol history: per channel, x[0..TAPS-1], with x[0] newest. On an accept with p=0, each channel shifts (x[k]<=x[k-1], x[0]<=i_symbols[c]). The sample accepted at that edge already uses the new history. i_symbols is ignored when p!=0.
- Stage 1 registers the phase used at the accept edge. Stage 2 (output register) computes, for each channel c, y_c = sum over k=0..TAPS-1 of coef[k*OS + p] * x_c[k], all signed.
- Full-precision width is S_COEF+S_IN+$clog2(TAPS)+1.
- Rounding: if OUT_SHIFT>0, add 2^(OUT_SHIFT-1), then arithmetic shift right by OUT_SHIFT (round half up). OUT_SHIFT=0 means no rounding.
- Saturation: clamp to [-2^(S_OUT-1), 2^(S_OUT-1)-1]. o_sat[c]=1 when clamping occurred.
- Latency: accept at edge t gives o_data, o_sat and o_valid updated at edge t+1. o_valid is high for exactly one cycle per accept. o_data and o_sat hold between strobes.
- Back-to-back i_valid every cycle is supported at full throughput.
- i_enable=0: no accepts. Phase forced to 0 synchronously; history held. o_valid=0 from the next edge; o_data held.
- i_clear=1 (priority over accept): phase=0, history=0, o_valid=0 at the next edge. Coefficients are untouched.
- Coefficient writes are accepted regardless of i_enable and i_clear. A write at edge t affects every sample accepted at edge >= t. Addresses >= TAPS*OS are ignored.
- Reset asserted mid-stream: immediate return to reset values. The first accept after release uses p=0.

Test Plan:
- Impulse: load coef[n]=n+1 (n=0..23); feed channel 0 symbol 1 then symbol 0 for 5 symbols, 1 sample per cycle -> o_data ch0 sequence is 1,2,...,24 then 0, each with o_valid one cycle after i_valid; ch1 (symbol 0) stays 0.
- Saturation: all coef=127, both channels symbol 1 for 6 symbols -> sum 762 clamps to 511 with o_sat=11. All coef=-128, symbol -2 -> 1536 clamps to 511. All coef=127, symbol -2 -> -1524 clamps to -512.
- Rounding: OUT_SHIFT=2, S_OUT=8, coef[0]=6, symbol 1 at p=0 -> 6+2=8, >>2 gives 2. coef[0]=-6 -> -6+2=-4, >>2 gives -1. o_sat=0 in both cases.
- Gapped strobes: i_valid every 3rd cycle with i_enable toggled low mid-symbol -> phase restarts at 0 after re-enable, no o_valid while disabled, o_data held.
- Live coef update: write coef[0]=50 on the same edge as a p=0 accept with symbol 1 -> that output is 50; the previous sample uses the old value.
- Clear/reset: assert i_clear, then resume -> outputs match a fresh start. Pulse i_reset low asynchronously mid-stream -> outputs 0 immediately, coefficients read back as 0 (impulse test gives all zeros).
